// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control, song ROM and tone outputs of the melody sequencer
interface melody_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        j;
    logic              busy;
    logic              note_strobe;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, rom_data,
        input  rom_addr, j, busy, note_strobe, done
    );

    modport slave (
        input  start, stop, pause, loop_en, rom_data,
        output rom_addr, j, busy, note_strobe, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - walks a song ROM and drives note index j with timed durations
module melody_sequencer #(
    parameter int TICK_CYCLES = 3125000,
    parameter int GAP_CYCLES  = 250000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    melody_sequencer_if.slave bus
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_FIRST = CW'(TICK_CYCLES - GAP_CYCLES);
    localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        j_q, j_d;
    logic [4:0]        note_q, note_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [2:0]        unit_q, unit_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;

    logic [4:0] note_in;
    logic [2:0] dur_in;
    assign note_in = bus.rom_data[7:3];
    assign dur_in  = bus.rom_data[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            j_q      <= '0;
            note_q   <= '0;
            cyc_q    <= '0;
            unit_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            j_q      <= j_d;
            note_q   <= note_d;
            cyc_q    <= cyc_d;
            unit_q   <= unit_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        j_d      = j_q;
        note_d   = note_q;
        cyc_d    = cyc_q;
        unit_d   = unit_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                j_d = '0;
                if (bus.start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                j_d     = '0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dur_in == 3'd0) begin
                    j_d = '0;
                    if (bus.loop_en) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    note_d   = (note_in != 5'd0 && note_in <= 5'd28) ? note_in : 5'd0;
                    j_d      = note_d;
                    strobe_d = 1'b1;
                    cyc_d    = '0;
                    unit_d   = dur_in;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                // unit_q counts remaining duration units including the current one
                if (bus.pause) begin
                    j_d = '0;
                end else if (cyc_q == TICK_LAST && unit_q == 3'd1) begin
                    j_d     = '0;
                    cyc_d   = '0;
                    unit_d  = '0;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    if (cyc_q == TICK_LAST) begin
                        cyc_d  = '0;
                        unit_d = unit_q - 3'd1;
                    end else begin
                        cyc_d  = cyc_q + 1'b1;
                    end
                    j_d = (HAS_GAP && unit_d == 3'd1 && cyc_d >= GAP_FIRST) ? 5'd0 : note_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.stop) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            j_d      = '0;
            cyc_d    = '0;
            unit_d   = '0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign bus.rom_addr    = addr_q;
    assign bus.j           = j_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.note_strobe = strobe_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer against a song-level model
module tb_melody_sequencer;
    localparam int TICK = 10;
    localparam int GAP  = 2;
    localparam int AW   = 6;
    localparam int SIZE = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    melody_sequencer_if #(.ADDR_W(AW)) bus ();

    melody_sequencer #(
        .TICK_CYCLES(TICK),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] rom [SIZE];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // song-level model: silent lead-in cycles, then a note occupying len cycles
    bit m_run;
    int m_silent, m_addr, m_pos, m_len, m_note;
    int e_j;
    bit e_strobe, e_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [7:0] word;
        int d, n;
        e_strobe = 1'b0;
        e_done   = 1'b0;
        if (rst || bus.stop) begin
            m_run = 1'b0; m_addr = 0; m_silent = 0; e_j = 0;
        end else if (!m_run) begin
            e_j = 0;
            if (bus.start) begin
                m_run = 1'b1; m_addr = 0; m_silent = 2;
            end
        end else if (m_silent == 2) begin
            m_silent = 1; e_j = 0;
        end else if (m_silent == 1) begin
            word = rom[m_addr];
            d = int'(word[2:0]);
            n = int'(word[7:3]);
            e_j = 0;
            if (d == 0) begin
                if (bus.loop_en) begin
                    m_addr = 0; m_silent = 2;
                end else begin
                    m_run = 1'b0; e_done = 1'b1;
                end
            end else begin
                m_silent = 0;
                m_len    = d * TICK;
                m_pos    = 0;
                m_note   = (n >= 1 && n <= 28) ? n : 0;
                e_j      = m_note;
                e_strobe = 1'b1;
            end
        end else if (bus.pause) begin
            e_j = 0;
        end else if (m_pos == m_len - 1) begin
            m_addr = (m_addr + 1) % SIZE; m_silent = 2; e_j = 0;
        end else begin
            m_pos++;
            e_j = (m_pos >= m_len - GAP) ? 0 : m_note;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("j",           bus.j,           e_j);
        chk("busy",        bus.busy,        m_run);
        chk("note_strobe", bus.note_strobe, e_strobe);
        chk("done",        bus.done,        e_done);
        chk("rom_addr",    bus.rom_addr,    m_addr);
    endtask

    task automatic wait_strobe(input string tag, input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.note_strobe && n < bound);
        chk(tag, bus.note_strobe, 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (bus.busy && n < bound) begin
            tick();
            n++;
        end
        chk(tag, bus.busy, 0);
    endtask

    initial begin
        int n8, n12, ndone, first_strobe, s1, prev_obs, nstrobe, wrapped, n;
        int sq[$];

        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
        for (int i = 0; i < SIZE; i++) rom[i] = 8'h00;
        m_run = 1'b0; m_addr = 0; m_silent = 0; e_j = 0;
        rom[0] = {5'd8, 3'd2};
        rom[1] = {5'd12, 3'd1};
        rom[2] = {5'd0, 3'd0};
        tick(); tick();
        rst = 1'b0;
        tick();

        // plain playback of the three-entry song
        n8 = 0; n12 = 0; ndone = 0; first_strobe = -1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 60; k++) begin
            tick();
            if (bus.j == 5'd8) n8++;
            if (bus.j == 5'd12) n12++;
            if (bus.done) ndone++;
            if (bus.note_strobe && first_strobe < 0) first_strobe = k;
        end
        chk("first_strobe_latency", first_strobe, 2);
        chk("note8_audible_cycles", n8, 2 * TICK - GAP);
        chk("note12_audible_cycles", n12, TICK - GAP);
        chk("done_pulses", ndone, 1);
        chk("idle_after_song", bus.busy, 0);

        // looping: marker restarts from address 0 with no done pulse
        bus.loop_en = 1'b1;
        ndone = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (bus.done) ndone++;
            if (bus.note_strobe) sq.push_back(k);
        end
        chk("loop_done_pulses", ndone, 0);
        chk("loop_strobes", sq.size(), 6);
        chk("loop_song_period", sq[2] - sq[0], 3 * TICK + 6);
        chk("loop_marker_gap", sq[2] - sq[1], TICK + 4);
        bus.loop_en = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // pause for 5 cycles inside note 8
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_strobe("pause_first_strobe", 5);
        s1 = cyc;
        repeat (3) tick();
        bus.pause = 1'b1;
        repeat (5) begin
            tick();
            chk("paused_silent", bus.j, 0);
        end
        bus.pause = 1'b0;
        wait_strobe("pause_second_strobe", 40);
        chk("paused_note_period", cyc - s1, 2 * TICK + 5 + 2);
        wait_idle("pause_song_end", 40);

        // stop beats start during note 12
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_strobe("stop_first_strobe", 5);
        wait_strobe("stop_second_strobe", 30);
        repeat (3) tick();
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        chk("stop_j", bus.j, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_rom_addr", bus.rom_addr, 0);
        bus.stop = 1'b0; bus.start = 1'b0;
        repeat (5) tick();
        chk("stays_idle", bus.busy, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // random full table without end marker, random pause/start/loop_en noise
        for (int i = 0; i < SIZE; i++)
            rom[i] = {5'($urandom_range(0, 31)), 3'($urandom_range(1, 2))};
        rom[5] = {5'd31, 3'd1};
        bus.start = 1'b1;
        tick();
        wrapped = 0; ndone = 0; nstrobe = 0; n = 0;
        while (!wrapped && n < 20000) begin
            bus.pause   = ($urandom_range(0, 7) == 0);
            bus.start   = $urandom_range(0, 1) == 1;
            bus.loop_en = $urandom_range(0, 1) == 1;
            prev_obs = int'(bus.rom_addr);
            tick();
            n++;
            if (bus.done) ndone++;
            if (bus.note_strobe) nstrobe++;
            if (prev_obs == SIZE - 1 && bus.rom_addr == '0 && bus.busy) wrapped = 1;
        end
        chk("addr_wrapped", wrapped, 1);
        chk("wrap_done_pulses", ndone, 0);
        chk("wrap_strobes", nstrobe, SIZE);
        bus.pause = 1'b0; bus.start = 1'b0; bus.loop_en = 1'b0;

        // reset in the middle of a note
        wait_strobe("rst_strobe", 60);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_j", bus.j, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
